// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants, types and index helper
package rf_pkg;

  localparam int REG_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_COUNT      = 32;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]      reg_data_t;

  // Next index in a ring of n requesters.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot round-robin arbiter owning the last_grant pointer
// The search starts one past the previous winner; reset favours requester 0.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_grant;
  logic [IW-1:0] grant_idx;
  logic          found;
  int            cur;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    cur       = int'(last_grant);
    for (int k = 0; k < N; k++) begin
      cur = wrap_inc(cur, N);
      if (!found && req[IW'(cur)]) begin
        grant[IW'(cur)] = 1'b1;
        grant_idx       = IW'(cur);
        found           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(N - 1);
    end else if (|grant) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between NUM_REQ writeback sources
// Define RFARB_FWD_EN to add the fwd_addr/fwd_hit/fwd_data bypass ports.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int REG_WIDTH      = rf_pkg::REG_WIDTH,
  parameter int REG_ADDR_WIDTH = rf_pkg::REG_ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]        req_data,
  output logic                                wr_en,
  output logic [REG_ADDR_WIDTH-1:0]           wr_addr,
  output logic [REG_WIDTH-1:0]                wr_data,
  output logic                                busy
`ifdef RFARB_FWD_EN
  ,
  input  logic [REG_ADDR_WIDTH-1:0]           fwd_addr,
  output logic                                fwd_hit,
  output logic [REG_WIDTH-1:0]                fwd_data
`endif
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(ZERO_REG);

  logic [NUM_REQ-1:0]        buf_full;
  logic [REG_ADDR_WIDTH-1:0] buf_addr [NUM_REQ];
  logic [REG_WIDTH-1:0]      buf_data [NUM_REQ];
  logic [REG_ADDR_WIDTH-1:0] in_addr  [NUM_REQ];
  logic [REG_WIDTH-1:0]      in_data  [NUM_REQ];
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        accept;
  logic [NUM_REQ-1:0]        load;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [REG_WIDTH-1:0]      sel_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign in_addr[g] = req_addr[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign in_data[g] = req_data[g*REG_WIDTH +: REG_WIDTH];
    // A handshake to r0 completes but never occupies the buffer.
    assign load[g]    = accept[g] && (in_addr[g] != ZERO_ADDR);
  end

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (buf_full),
    .grant (grant)
  );

  // Grant comes from registered state only, so ready never depends on valid.
  assign req_ready = ~buf_full | grant;
  assign accept    = req_valid & req_ready;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr |= buf_addr[i] & {REG_ADDR_WIDTH{grant[i]}};
      sel_data |= buf_data[i] & {REG_WIDTH{grant[i]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_addr[i] <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load[i]) begin
          buf_full[i] <= 1'b1;
          buf_addr[i] <= in_addr[i];
          buf_data[i] <= in_data[i];
        end else if (grant[i]) begin
          buf_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= |grant;
      if (|grant) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

  assign busy = (|buf_full) || wr_en;

`ifdef RFARB_FWD_EN
  assign fwd_hit  = wr_en && (wr_addr == fwd_addr) && (fwd_addr != ZERO_ADDR);
  assign fwd_data = fwd_hit ? wr_data : '0;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between N writeback requesters (ALU, load unit, link/PC+4, etc.).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains one buffer per cycle into a registered write port that drives the register file's writeEnable, write_reg and write_data.
- Writes to register 0 are discarded so that r0 stays zero.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- REG_WIDTH, 32, data width of a register.
- REG_ADDR_WIDTH, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester accept; a request transfers when valid && ready at a rising edge.
- req_addr  in  NUM_REQ*REG_ADDR_WIDTH  packed destination register; requester i occupies slice [i*W +: W].
- req_data  in  NUM_REQ*REG_WIDTH  packed write data, same packing as req_addr.
- wr_en  out  1  to register file writeEnable.
- wr_addr  out  REG_ADDR_WIDTH  to register file write_reg.
- wr_data  out  REG_WIDTH  to register file write_data.
- busy  out  1  asserted when any buffer is full or wr_en is high.

Behaviour:
- Reset (asynchronous assertion, synchronous release):
  - All buffers are emptied.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0.
  - RR pointer set so that requester 0 has highest priority.
  - Any in-flight or buffered write is lost.
- Buffers: buf_full[i], buf_addr[i], buf_data[i].
  - req_ready[i] = !buf_full[i] || grant[i].
  - grant depends only on registered state, so there is no combinational path from req_valid to req_ready.
- Acceptance with req_addr==0: the handshake completes (ready honoured) but the buffer is not loaded; the write is silently dropped.
- Arbitration:
  - Each cycle, grant is one-hot over buf_full.
  - Search starts at last_grant+1 modulo NUM_REQ.
  - When no buffer is full, grant is 0.
  - last_grant updates only when grant != 0.
- Output register, at each rising edge:
  - wr_en <= |grant.
  - wr_addr and wr_data are loaded from the granted buffer.
  - When there is no grant, wr_addr and wr_data hold their previous values and wr_en=0.
- Latency:
  - Accept at edge T. Buffer is full during T..T+1.
  - Grant, if uncontested, is in the cycle after T; wr_en is high from edge T+1.
  - The register file commits at edge T+2.
- Buffer update, in the same edge: grant clears the buffer, a new handshake loads it. A simultaneous grant and accept on the same buffer leaves it full with the new entry.
- Throughput: one write per cycle total. A lone requester sustains 1/cycle.
- Fairness: with all NUM_REQ buffers continuously full, each requester is granted exactly once every NUM_REQ cycles.
- Same destination from two requesters: writes are serialized in grant order, and the last-granted value persists. No merging or reordering within a requester.
- busy = |buf_full || wr_en.

Optional Feature:
- RFARB_FWD_EN defined:
  - Adds ports fwd_addr (in, REG_ADDR_WIDTH), fwd_hit (out, 1) and fwd_data (out, REG_WIDTH).
  - fwd_hit = wr_en && (wr_addr == fwd_addr) && (fwd_addr != 0), computed combinationally.
  - fwd_data = wr_data when fwd_hit is high, else 0.
  - Purpose: lets a reader see the value the register file commits at the next edge.
- RFARB_FWD_EN undefined: the three ports and their logic are absent.

Decomposition:
- Package rf_pkg:
  - constants REG_WIDTH=32, REG_ADDR_WIDTH=5, REG_COUNT=32, ZERO_REG=5'd0;
  - typedefs reg_addr_t and reg_data_t.
- One sub-module, rr_arbiter: parameter N; inputs clk, rst_n, req[N]; output grant[N] (one-hot); owns the last_grant pointer.
- Buffers and the output register stay in the top module.

Test Plan:
- Reset, then a single write: req0 = (addr 5, data 0xDEADBEEF) accepted at edge 1 → wr_en=1, wr_addr=5, wr_data=0xDEADBEEF in the cycle after edge 2; busy is low again after that cycle.
- Register-0 drop: req1 = (addr 0, data 0x1234) → req_ready=1, wr_en never asserts, busy stays 0.
- Round-robin fairness: NUM_REQ=3, all three valid every cycle with distinct addrs 2, 3, 4 → wr_addr sequence 2, 3, 4, 2, 3, 4…, with wr_en continuously high after the first two cycles.
- Back-pressure: req0 and req1 accepted the same cycle (addr 6 and 7) → req1's buffer holds for one cycle; the sequence is 6 then 7; both are accepted without loss.
- Same-address collision: req0 (addr 7, 0xAAAA) and req2 (addr 7, 0xBBBB) in the same cycle → two writes in grant order 0 then 2; final wr_data for addr 7 = 0xBBBB.
- Mid-operation reset: rst_n low while wr_en=1 and two buffers are full → wr_en drops immediately (asynchronously); after release, no stale write appears and the first grant goes to requester 0. With RFARB_FWD_EN: fwd_addr=3 while wr_en=1 and wr_addr=3 → fwd_hit=1 and fwd_data=wr_data in the same cycle.
